// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, bus widths and FSM states for the memory stage
package mem_pkg;

  localparam int EXE_MEM_W = 157;
  localparam int MEM_WB_W  = 121;

  // mem_control bit positions; MEM_CTL_SIZE is the low bit of the 2-bit size field
  localparam int MEM_CTL_LOAD  = 5;
  localparam int MEM_CTL_STORE = 4;
  localparam int MEM_CTL_SIZE  = 2;
  localparam int MEM_CTL_SIGN  = 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Size 2'b11 is treated as a word access, so it shares the word alignment rule
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr[0];
      default: return |addr;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - lane select and sign/zero extension of a loaded word
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte/half (little-endian lanes) and extend to 32 bits
  always_comb begin
    case (addr)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: result = {{24{sign & byte_v[7]}}, byte_v};
      SZ_HALF: result = {{16{sign & half_v[15]}}, half_v};
      SZ_WORD: result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage: stores, latency-counted loads, alignment faults
module mem_stage
  import mem_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_valid,
  input  logic                 MEM_allow_in,
  input  logic                 MEM_cancel,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic [31:0]          dm_rdata,
  output logic [31:0]          dm_addr,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_wdata,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic [31:0]          MEM_pc
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LOAD_LATENCY);

  logic [5:0]  mem_control;
  logic [31:0] store_data, exe_result, lo_result, pc;
  logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall, brk, eret, rf_wen;
  logic [4:0]  rf_wdest;

  assign {mem_control, store_data, exe_result, lo_result, hi_write, lo_write,
          mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, brk, eret, rf_wen,
          rf_wdest, pc} = EXE_MEM_bus_r;

  // mem_control[0] is reserved and intentionally ignored
  logic unused_rsvd;
  assign unused_rsvd = mem_control[0];

  logic       is_load, is_store, load_sign, mis, adel, ades;
  logic       mem_load, store_fire;
  logic [1:0] size;

  assign is_load   = mem_control[MEM_CTL_LOAD];
  assign is_store  = mem_control[MEM_CTL_STORE];
  assign size      = mem_control[MEM_CTL_SIZE+1:MEM_CTL_SIZE];
  assign load_sign = mem_control[MEM_CTL_SIGN];
  assign mis       = misaligned(size, exe_result[1:0]);
  assign adel      = is_load & mis;
  assign ades      = is_store & mis;
  // Only an aligned load waits on the RAM; faulting loads finish immediately
  assign mem_load  = is_load & ~mis;

  mem_state_e       state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             store_done;
  logic [31:0]      rdata_q;

  assign cnt_nxt = cnt + CNT_W'(1);

  // Write fires once per instruction; store_done blocks repeats while the stage stalls
  assign store_fire = ~rst & MEM_valid & ~MEM_cancel & is_store & ~mis & ~store_done;

  logic [3:0]  lanes;
  logic [31:0] lane_data;

  // Byte-enable pattern and lane-replicated data for the store size
  always_comb begin
    lanes     = 4'h0;
    lane_data = store_data;
    case (size)
      SZ_BYTE: begin
        lanes     = 4'b0001 << exe_result[1:0];
        lane_data = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        lanes     = exe_result[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{store_data[15:0]}};
      end
      default: begin
        lanes     = 4'hF;
        lane_data = store_data;
      end
    endcase
  end

  // Load FSM, latency counter, captured read data and store-commit flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      store_done <= 1'b0;
      rdata_q    <= '0;
    end else if (MEM_cancel) begin
      state      <= IDLE;
      cnt        <= '0;
      store_done <= 1'b0;
    end else begin
      if (MEM_allow_in)
        store_done <= 1'b0;
      else if (store_fire)
        store_done <= 1'b1;
      case (state)
        IDLE: begin
          if (MEM_valid && mem_load) begin
            cnt <= CNT_W'(1);
            if (LOAD_LATENCY == 1) begin
              rdata_q <= dm_rdata;
              state   <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (cnt_nxt == LAT_CNT) begin
            rdata_q <= dm_rdata;
            state   <= DONE;
          end
        end
        DONE: begin
          if (MEM_allow_in) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] load_result, mem_result;

  mem_load_align u_align (
    .rdata  (rdata_q),
    .addr   (exe_result[1:0]),
    .size   (size),
    .sign   (load_sign),
    .result (load_result)
  );

  assign mem_result = mem_load ? load_result : exe_result;
  assign MEM_over   = ~rst & MEM_valid & ~MEM_cancel & (~mem_load | (state == DONE));
  assign dm_addr    = {exe_result[31:2], 2'b00};
  assign dm_wen     = store_fire ? lanes : 4'h0;
  assign dm_wdata   = lane_data;
  assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
  assign MEM_pc     = pc;
  assign MEM_WB_bus = {mem_result, lo_result, hi_write, lo_write, mfhi, mflo,
                       mtc0, mfc0, cp0r_addr, syscall, brk, eret, adel, ades,
                       rf_wen, rf_wdest, pc};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage at load latencies 1 and 3
module tb_mem_stage;
  import mem_pkg::*;

  localparam logic [31:0] TB_LO    = 32'hCAFE0001;
  localparam logic [5:0]  TB_FLAGS = 6'b101010;
  localparam logic [7:0]  TB_CP0R  = 8'h5A;
  localparam logic [2:0]  TB_SYS   = 3'b010;
  localparam logic [4:0]  TB_DEST  = 5'd7;

  localparam logic [5:0] C_ADD = 6'b000001, C_SB  = 6'b010000, C_SH  = 6'b010100;
  localparam logic [5:0] C_SW  = 6'b011000, C_LB  = 6'b100010, C_LBU = 6'b100000;
  localparam logic [5:0] C_LH  = 6'b100110, C_LHU = 6'b100100, C_LW  = 6'b101000;
  localparam logic [5:0] C_LX  = 6'b101100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, v1, v3, allow_in, cancel;
  logic [156:0] bus;
  logic [31:0]  rdata;
  logic [31:0]  addr1, wdata1, pc1, addr3, wdata3, pc3;
  logic [3:0]   wen1, wen3;
  logic         over1, over3;
  logic [120:0] wb1, wb3;
  logic [4:0]   wd1, wd3;

  mem_stage #(.LOAD_LATENCY(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .MEM_valid(v1), .MEM_allow_in(allow_in), .MEM_cancel(cancel),
    .EXE_MEM_bus_r(bus), .dm_rdata(rdata), .dm_addr(addr1), .dm_wen(wen1),
    .dm_wdata(wdata1), .MEM_over(over1), .MEM_WB_bus(wb1), .MEM_wdest(wd1), .MEM_pc(pc1));

  mem_stage #(.LOAD_LATENCY(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .MEM_valid(v3), .MEM_allow_in(allow_in), .MEM_cancel(cancel),
    .EXE_MEM_bus_r(bus), .dm_rdata(rdata), .dm_addr(addr3), .dm_wen(wen3),
    .dm_wdata(wdata3), .MEM_over(over3), .MEM_WB_bus(wb3), .MEM_wdest(wd3), .MEM_pc(pc3));

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] sdata, exe, rd;
    logic [3:0]  wen;
    logic [31:0] wdata, result;
    logic        adel, ades;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] result, pc;
    logic        adel, ades;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected one", name);
  endtask

  function automatic logic [156:0] mk_bus(input logic [5:0] ctl, input logic [31:0] sd,
                                          input logic [31:0] exe, input logic [31:0] pc);
    return {ctl, sd, exe, TB_LO, TB_FLAGS, TB_CP0R, TB_SYS, 1'b1, TB_DEST, pc};
  endfunction

  function automatic vec_t mkv(input logic [5:0] ctl, input logic [31:0] sd, input logic [31:0] exe,
                               input logic [31:0] rd, input logic [3:0] wen, input logic [31:0] wd,
                               input logic [31:0] res, input logic adel, input logic ades,
                               input int lat);
    vec_t v;
    v.ctl = ctl; v.sdata = sd; v.exe = exe; v.rd = rd; v.wen = wen; v.wdata = wd;
    v.result = res; v.adel = adel; v.ades = ades; v.lat = lat;
    return v;
  endfunction

  task automatic push_exp(input logic [31:0] res, input logic adel, input logic ades,
                          input logic [31:0] pc);
    exp_t e;
    e.result = res; e.adel = adel; e.ades = ades; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [120:0] wb, input logic [31:0] mpc);
    exp_t e;
    if (sb.size() == 0) begin
      fail_now("scoreboard_empty");
    end else begin
      e = sb.pop_front();
      chk("mem_result", 64'(wb[120:89]), 64'(e.result));
      chk("adel", 64'(wb[39]), 64'(e.adel));
      chk("ades", 64'(wb[38]), 64'(e.ades));
      chk("passthru_hi", 64'(wb[88:40]), 64'({TB_LO, TB_FLAGS, TB_CP0R, TB_SYS}));
      chk("passthru_lo", 64'(wb[37:0]), 64'({1'b1, TB_DEST, e.pc}));
      chk("MEM_pc", 64'(mpc), 64'(e.pc));
    end
  endtask

  // One instruction on the latency-1 instance; ends it with MEM_allow_in when MEM_over shows
  task automatic run_vec(input vec_t v, input logic [31:0] pc);
    logic done;
    bus = mk_bus(v.ctl, v.sdata, v.exe, pc);
    rdata = v.rd;
    v1 = 1'b1;
    push_exp(v.result, v.adel, v.ades, pc);
    done = 1'b0;
    for (int cyc = 1; cyc <= 8 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("dm_wen", 64'(wen1), 64'(v.wen));
        chk("dm_addr", 64'(addr1), 64'(v.exe & ~32'h3));
        chk("MEM_wdest", 64'(wd1), 64'(TB_DEST));
        if (v.wen != 4'h0) chk("dm_wdata", 64'(wdata1), 64'(v.wdata));
      end else begin
        chk("dm_wen_once", 64'(wen1), 64'(0));
      end
      if (over1) begin
        chk("latency", 64'(cyc), 64'(v.lat));
        pop_check(wb1, pc1);
        allow_in = 1'b1;
        done = 1'b1;
      end
      @(posedge clk); #1;
      allow_in = 1'b0;
    end
    v1 = 1'b0;
    if (!done) fail_now("over_timeout");
  endtask

  // Aligned load on the latency-3 instance: MEM_over must appear exactly in cycle 4
  task automatic run_load3(input logic [5:0] ctl, input logic [31:0] exe, input logic [31:0] rd,
                           input logic [31:0] res, input logic [31:0] pc);
    bus = mk_bus(ctl, 32'h0, exe, pc);
    rdata = rd;
    v3 = 1'b1;
    push_exp(res, 1'b0, 1'b0, pc);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("l3_over", 64'(over3), 64'(c == 4));
      if (c == 4) begin
        if (over3) pop_check(wb3, pc3);
        else void'(sb.pop_front());
        allow_in = 1'b1;
      end
      @(posedge clk); #1;
      allow_in = 1'b0;
    end
    v3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; v1 = 1'b0; v3 = 1'b0; allow_in = 1'b0; cancel = 1'b0;
    bus = '0; rdata = '0;

    tbl.push_back(mkv(C_SW,  32'h12345678, 32'h10, 0, 4'hF, 32'h12345678, 32'h10, 0, 0, 1));
    tbl.push_back(mkv(C_LB,  0, 32'h13, 32'h80FF0000, 4'h0, 0, 32'hFFFFFF80, 0, 0, 2));
    tbl.push_back(mkv(C_LBU, 0, 32'h13, 32'h80FF0000, 4'h0, 0, 32'h00000080, 0, 0, 2));
    tbl.push_back(mkv(C_SH,  32'h0000ABCD, 32'h22, 0, 4'hC, 32'hABCDABCD, 32'h22, 0, 0, 1));
    tbl.push_back(mkv(C_LH,  0, 32'h22, 32'h80011234, 4'h0, 0, 32'hFFFF8001, 0, 0, 2));
    tbl.push_back(mkv(C_LW,  0, 32'h6, 32'h11111111, 4'h0, 0, 32'h6, 1, 0, 1));
    tbl.push_back(mkv(C_SW,  32'h99999999, 32'h2, 0, 4'h0, 0, 32'h2, 0, 1, 1));
    tbl.push_back(mkv(C_SB,  32'h000000A5, 32'h11, 0, 4'h2, 32'hA5A5A5A5, 32'h11, 0, 0, 1));
    tbl.push_back(mkv(C_SB,  32'hFFFFFF3C, 32'h13, 0, 4'h8, 32'h3C3C3C3C, 32'h13, 0, 0, 1));
    tbl.push_back(mkv(C_SH,  32'h00001234, 32'h21, 0, 4'h0, 0, 32'h21, 0, 1, 1));
    tbl.push_back(mkv(C_SH,  32'h00005AA5, 32'h20, 0, 4'h3, 32'h5AA55AA5, 32'h20, 0, 0, 1));
    tbl.push_back(mkv(C_LHU, 0, 32'h20, 32'h1234F00D, 4'h0, 0, 32'h0000F00D, 0, 0, 2));
    tbl.push_back(mkv(C_LH,  0, 32'h23, 32'h0, 4'h0, 0, 32'h23, 1, 0, 1));
    tbl.push_back(mkv(C_LW,  0, 32'h40, 32'hDEADBEEF, 4'h0, 0, 32'hDEADBEEF, 0, 0, 2));
    tbl.push_back(mkv(C_LX,  0, 32'h44, 32'h01020304, 4'h0, 0, 32'h01020304, 0, 0, 2));
    tbl.push_back(mkv(C_ADD, 0, 32'h12345677, 0, 4'h0, 0, 32'h12345677, 0, 0, 1));
    tbl.push_back(mkv(C_LB,  0, 32'h11, 32'h00007F00, 4'h0, 0, 32'h0000007F, 0, 0, 2));
    tbl.push_back(mkv(C_LB,  0, 32'h10, 32'h000000FE, 4'h0, 0, 32'hFFFFFFFE, 0, 0, 2));

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_over1", 64'(over1), 64'(0));
    chk("rst_wen1", 64'(wen1), 64'(0));
    chk("rst_over3", 64'(over3), 64'(0));
    chk("rst_wdest", 64'(wd1), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_state1", 64'(u_dut1.state), 64'(IDLE));
    chk("rst_cnt3", 64'(u_dut3.cnt), 64'(0));
    chk("rst_rdata_q", 64'(u_dut1.rdata_q), 64'(0));

    // SW held valid for three cycles: single write, MEM_over from cycle 1; then back-to-back SW
    bus = mk_bus(C_SW, 32'h12345678, 32'h10, 32'h1000);
    v1 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("sw_hold_wen", 64'(wen1), 64'(c == 1 ? 4'hF : 4'h0));
      chk("sw_hold_over", 64'(over1), 64'(1));
      chk("sw_hold_addr", 64'(addr1), 64'(32'h10));
      if (c == 3) allow_in = 1'b1;
      @(posedge clk); #1;
      allow_in = 1'b0;
    end
    bus = mk_bus(C_SW, 32'h00000055, 32'h14, 32'h1004);
    @(negedge clk);
    chk("sw_next_wen", 64'(wen1), 64'(4'hF));
    chk("sw_next_wdata", 64'(wdata1), 64'(32'h55));
    allow_in = 1'b1;
    @(posedge clk); #1;
    allow_in = 1'b0; v1 = 1'b0;

    // Misaligned SW held: never writes
    bus = mk_bus(C_SW, 32'hFFFFFFFF, 32'h2, 32'h1008);
    v1 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("ades_wen", 64'(wen1), 64'(0));
      chk("ades_flag", 64'(wb1[38]), 64'(1));
      if (c == 3) allow_in = 1'b1;
      @(posedge clk); #1;
      allow_in = 1'b0;
    end
    v1 = 1'b0;

    // Cancelled store does not write; the next store writes normally
    bus = mk_bus(C_SW, 32'h77777777, 32'h30, 32'h100C);
    v1 = 1'b1; cancel = 1'b1;
    @(negedge clk);
    chk("cancel_st_wen", 64'(wen1), 64'(0));
    chk("cancel_st_over", 64'(over1), 64'(0));
    @(posedge clk); #1;
    cancel = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    bus = mk_bus(C_SW, 32'h88888888, 32'h34, 32'h1010);
    v1 = 1'b1;
    @(negedge clk);
    chk("post_cancel_wen", 64'(wen1), 64'(4'hF));
    allow_in = 1'b1;
    @(posedge clk); #1;
    allow_in = 1'b0; v1 = 1'b0;

    // Table of single instructions, issued back to back
    foreach (tbl[i]) run_vec(tbl[i], 32'h2000 + 32'(i) * 4);

    // Latency 3: two loads back to back (allow_in coincides with DONE)
    run_load3(C_LW, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, 32'h3000);
    run_load3(C_LH, 32'h42, 32'hFFEE0000, 32'hFFFFFFEE, 32'h3004);

    // Latency 3: cancel in cycle 2 of a load; then an ADD finishes at once
    bus = mk_bus(C_LW, 32'h0, 32'h48, 32'h3008);
    rdata = 32'h12121212;
    v3 = 1'b1;
    @(negedge clk);
    chk("cxl_over_c1", 64'(over3), 64'(0));
    @(posedge clk); #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cxl_over_c2", 64'(over3), 64'(0));
    chk("cxl_wen_c2", 64'(wen3), 64'(0));
    @(posedge clk); #1;
    cancel = 1'b0; v3 = 1'b0;
    @(negedge clk);
    chk("cxl_state", 64'(u_dut3.state), 64'(IDLE));
    chk("cxl_cnt", 64'(u_dut3.cnt), 64'(0));
    chk("cxl_over_c3", 64'(over3), 64'(0));
    @(posedge clk); #1;
    bus = mk_bus(C_ADD, 32'h0, 32'h99, 32'h300C);
    v3 = 1'b1;
    @(negedge clk);
    chk("add_over", 64'(over3), 64'(1));
    chk("add_result", 64'(wb3[120:89]), 64'(32'h99));
    allow_in = 1'b1;
    @(posedge clk); #1;
    allow_in = 1'b0; v3 = 1'b0;

    // Latency 3: reset during WAIT, then the same load completes after the full latency
    bus = mk_bus(C_LW, 32'h0, 32'h50, 32'h3010);
    rdata = 32'hA5A50F0F;
    v3 = 1'b1;
    @(negedge clk);
    chk("rstw_over_c1", 64'(over3), 64'(0));
    @(posedge clk); #1;
    chk("rstw_in_wait", 64'(u_dut3.state), 64'(WAIT));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstw_state", 64'(u_dut3.state), 64'(IDLE));
    chk("rstw_cnt", 64'(u_dut3.cnt), 64'(0));
    chk("rstw_wen", 64'(wen3), 64'(0));
    chk("rstw_over", 64'(over3), 64'(0));
    run_load3(C_LW, 32'h50, 32'hA5A50F0F, 32'hA5A50F0F, 32'h3010);

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
